mem_arbiter: RTL

//  Shares one multi-cycle memory port (mem_system style Rd/Wr/Done handshake) between the fetch

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the shared memory port arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_flush;
  logic [15:0] i_data;
  logic        i_done;
  logic        i_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_done;
  logic        m_err;
  logic        err;

  modport slave (
    input  i_req, i_addr, i_flush, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_done, m_err,
    output i_data, i_done, i_stall, d_rdata, d_done, d_stall, m_rd, m_wr, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, i_flush, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_done, m_err,
    input  i_data, i_done, i_stall, d_rdata, d_done, d_stall, m_rd, m_wr, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between fetch and data requesters.
// Done pulse one cycle after m_done; requesters see stall until their done pulse.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t        state_q, state_d;
  logic          m_rd_q, m_rd_d, m_wr_q, m_wr_d;
  logic [15:0]   m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [15:0]   i_data_q, i_data_d, d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d, d_done_q, d_done_d;
  logic          err_q, err_d, drop_q, drop_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [5:0]    tmo_q, tmo_d;
  logic          fetch_ok, data_req, grant_i, grant_d, timed_out, finish, drop_now;
  logic [15:0]   ret_data;

  always_comb begin
    fetch_ok = bus.i_req & ~bus.i_flush;
    data_req = bus.d_rd | bus.d_wr;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    // Data wins by default; a starved fetch overrides once the limit is hit.
    if (state_q == IDLE) begin
      if (fetch_ok && starve_q == SW'(STARVE_MAX)) grant_i = 1'b1;
      else if (data_req)                           grant_d = 1'b1;
      else if (fetch_ok)                           grant_i = 1'b1;
    end
    timed_out = (state_q != IDLE) && !bus.m_done && (tmo_q == 6'(TIMEOUT - 1));
    finish    = (state_q != IDLE) && (bus.m_done || timed_out);
    drop_now  = drop_q | bus.i_flush;
    ret_data  = bus.m_done ? bus.m_rdata : 16'h0000;
  end

  always_comb begin
    state_d   = state_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = err_q;
    drop_d    = drop_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;

    if (grant_i) begin
      state_d  = I_BUSY;
      m_rd_d   = 1'b1;
      m_wr_d   = 1'b0;
      m_addr_d = bus.i_addr;
      tmo_d    = '0;
    end
    if (grant_d) begin
      state_d   = D_BUSY;
      m_rd_d    = bus.d_rd & ~bus.d_wr;
      m_wr_d    = bus.d_wr;
      m_addr_d  = bus.d_addr;
      m_wdata_d = bus.d_wdata;
      tmo_d     = '0;
      if (bus.d_rd && bus.d_wr) err_d = 1'b1;
    end

    // A flushed fetch cannot be aborted at the memory; only its result is discarded.
    if (state_q == I_BUSY && bus.i_flush) drop_d = 1'b1;
    if (state_q != IDLE && !finish) tmo_d = tmo_q + 6'd1;

    if (finish) begin
      state_d = IDLE;
      m_rd_d  = 1'b0;
      m_wr_d  = 1'b0;
      drop_d  = 1'b0;
      if ((bus.m_done && bus.m_err) || timed_out) err_d = 1'b1;
      if (state_q == I_BUSY) begin
        if (!drop_now) begin
          i_done_d = 1'b1;
          i_data_d = ret_data;
        end
      end else begin
        d_done_d  = 1'b1;
        d_rdata_d = ret_data;
      end
    end

    if (!bus.i_req || grant_i)                         starve_d = '0;
    else if (grant_d && starve_q != SW'(STARVE_MAX))  starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      starve_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.m_rd    = m_rd_q;
  assign bus.m_wr    = m_wr_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_data  = i_data_q;
  assign bus.i_done  = i_done_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_done  = d_done_q;
  assign bus.err     = err_q;
  assign bus.i_stall = bus.i_req & ~i_done_q;
  assign bus.d_stall = (bus.d_rd | bus.d_wr) & ~d_done_q;
endmodule
